// File: rtl/fsqrt_issue_ctrl.sv
// fsqrt_issue_ctrl: launches the iterative sqrt unit, stalls the pipeline and arbitrates its FP write-back.
// Optional FSQRT_BYPASS_EN adds byp_hit_a/byp_hit_b/byp_data so a WB-stage hazard forwards instead of stalling.
module fsqrt_issue_ctrl #(
    parameter int TIMEOUT = 31,
    parameter int REGW    = 5
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic            enable,
    input  logic            flush,
    input  logic            id_fsqrt,
    input  logic [31:0]     id_fs,
    input  logic [1:0]      id_rm,
    input  logic [REGW-1:0] id_fd,
    input  logic [REGW-1:0] id_rs_a,
    input  logic [REGW-1:0] id_rs_b,
    output logic            u_fsqrt,
    output logic [31:0]     u_d,
    output logic [1:0]      u_rm,
    input  logic            u_busy,
    input  logic [31:0]     u_s,
    output logic            stall,
    output logic            wb_req,
    output logic [REGW-1:0] wb_fd,
    output logic [31:0]     wb_data,
    input  logic            wb_grant,
`ifdef FSQRT_BYPASS_EN
    output logic            byp_hit_a,
    output logic            byp_hit_b,
    output logic [31:0]     byp_data,
`endif
    output logic            timeout
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, WB} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_seen_q, busy_seen_d;
    logic            pending_q, pending_d;
    logic [REGW-1:0] pend_fd_q, pend_fd_d;
    logic [31:0]     u_d_q, u_d_d;
    logic [1:0]      u_rm_q, u_rm_d;
    logic [31:0]     wb_data_q, wb_data_d;
    logic            timeout_q, timeout_d;
    logic            active, hit_a, hit_b, haz_stall;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        busy_seen_d = busy_seen_q;
        pending_d   = pending_q;
        pend_fd_d   = pend_fd_q;
        u_d_d       = u_d_q;
        u_rm_d      = u_rm_q;
        wb_data_d   = wb_data_q;
        timeout_d   = timeout_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (id_fsqrt && enable && !flush) begin
                    state_d   = LAUNCH;
                    u_d_d     = id_fs;
                    u_rm_d    = id_rm;
                    pend_fd_d = id_fd;
                    pending_d = 1'b1;
                end
            end
            LAUNCH: begin
                cnt_d       = '0;
                busy_seen_d = 1'b0;
                state_d     = flush ? IDLE : WAIT;
                pending_d   = !flush;
            end
            WAIT: begin
                cnt_d       = cnt_q + CW'(1);
                busy_seen_d = busy_seen_q | u_busy;
                if (flush) begin
                    state_d   = IDLE;
                    pending_d = 1'b0;
                end else if (busy_seen_q && !u_busy) begin
                    state_d   = WB;
                    wb_data_d = u_s;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d   = IDLE;
                    pending_d = 1'b0;
                    timeout_d = 1'b1;
                end
            end
            WB: begin
                if (wb_grant) begin
                    state_d   = IDLE;
                    pending_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            busy_seen_q <= 1'b0;
            pending_q   <= 1'b0;
            pend_fd_q   <= '0;
            u_d_q       <= '0;
            u_rm_q      <= '0;
            wb_data_q   <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            busy_seen_q <= busy_seen_d;
            pending_q   <= pending_d;
            pend_fd_q   <= pend_fd_d;
            u_d_q       <= u_d_d;
            u_rm_q      <= u_rm_d;
            wb_data_q   <= wb_data_d;
            timeout_q   <= timeout_d;
        end
    end

    // Operand/result buses read as zero whenever they carry nothing meaningful.
    always_comb begin
        active  = state_q != IDLE;
        hit_a   = pending_q && (id_rs_a == pend_fd_q);
        hit_b   = pending_q && (id_rs_b == pend_fd_q);
        u_fsqrt = state_q == LAUNCH;
        u_d     = active ? u_d_q : '0;
        u_rm    = active ? u_rm_q : '0;
        wb_req  = state_q == WB;
        wb_fd   = wb_req ? pend_fd_q : '0;
        wb_data = wb_req ? wb_data_q : '0;
        timeout = timeout_q;
`ifdef FSQRT_BYPASS_EN
        byp_hit_a = wb_req && hit_a;
        byp_hit_b = wb_req && hit_b;
        byp_data  = (byp_hit_a || byp_hit_b) ? wb_data_q : '0;
        haz_stall = (hit_a || hit_b) && !wb_req;
`else
        haz_stall = hit_a || hit_b;
`endif
        stall = (state_q == LAUNCH) || (state_q == WAIT) || haz_stall || (id_fsqrt && active);
    end
endmodule
